dmx_frame_bank_arbiter: RTL and testbench

Ping-pong bank controller and read-port arbiter for the DMX frame-buffer EBR. The DMX receiver writes bytes into one bank through EBR port A, and up to N_REQ consumers (host readout, slot compare, etc.) read 64-bit words from the other bank through EBR port B. On each completed frame the block swaps the banks, unless a consumer holds a lock. It also round-robin arbitrates single-word reads and tracks frame length, sequence number and overruns.

---
 rtl/dmx_frame_bank_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmx_frame_bank_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_frame_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmx_frame_bank_arbiter
// Purpose  : Ping-pong frame-bank swap control plus round-robin read-port
//            arbiter for the DMX frame-buffer EBR.
// Revision : 1.0
// ============================================================================
module dmx_frame_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int RD_ADDR_W = 7,
    parameter int RD_DATA_W = 64,
    parameter int LEN_W     = 10,
    parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_done,
    input  logic [LEN_W-1:0]           frame_len,
    output logic                       wr_bank,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*RD_ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]           lock,
    output logic [N_REQ-1:0]           gnt,
    output logic                       ebr_rd_en,
    output logic [RD_ADDR_W:0]         ebr_addr_b,
    input  logic [RD_DATA_W-1:0]       ebr_qb,
    output logic                       rd_valid,
    output logic [ID_W-1:0]            rd_id,
    output logic [RD_DATA_W-1:0]       rd_data,
    output logic                       rd_bank,
    output logic                       frame_valid,
    output logic [LEN_W-1:0]           frame_len_rd,
    output logic [7:0]                 frame_seq,
    output logic [7:0]                 overrun_cnt,
    output logic                       swap_pending
);

    // ------------------------------------------------------------------
    // Frame capture and bank swap
    // ------------------------------------------------------------------
    logic             wr_bank_q,  wr_bank_d;
    logic             pend_q,     pend_d;
    logic [LEN_W-1:0] pend_len_q, pend_len_d;
    logic [LEN_W-1:0] len_rd_q,   len_rd_d;
    logic [7:0]       seq_q,      seq_d;
    logic [7:0]       ovr_q,      ovr_d;
    logic             fvalid_q,   fvalid_d;

    logic w_fd_valid;
    logic w_do_swap;

    assign w_fd_valid = frame_done && (frame_len != '0);
    assign w_do_swap  = (pend_q || w_fd_valid) && (lock == '0);

    always_comb begin
        wr_bank_d  = wr_bank_q;
        pend_d     = pend_q;
        pend_len_d = pend_len_q;
        len_rd_d   = len_rd_q;
        seq_d      = seq_q;
        ovr_d      = ovr_q;
        fvalid_d   = fvalid_q;

        if (w_fd_valid) begin
            pend_len_d = frame_len;
            if (pend_q && (ovr_q != 8'hFF))
                ovr_d = ovr_q + 8'd1;
        end

        if (w_do_swap) begin
            // Newest length wins when a frame lands on the release cycle
            wr_bank_d = ~wr_bank_q;
            len_rd_d  = w_fd_valid ? frame_len : pend_len_q;
            seq_d     = seq_q + 8'd1;
            fvalid_d  = 1'b1;
            pend_d    = 1'b0;
        end else if (w_fd_valid) begin
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_len_q <= '0;
            len_rd_q   <= '0;
            seq_q      <= '0;
            ovr_q      <= '0;
            fvalid_q   <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            pend_q     <= pend_d;
            pend_len_q <= pend_len_d;
            len_rd_q   <= len_rd_d;
            seq_q      <= seq_d;
            ovr_q      <= ovr_d;
            fvalid_q   <= fvalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin read arbiter
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]     gnt_q,   gnt_d;
    logic                 rd_en_q, rd_en_d;
    logic [RD_ADDR_W:0]   addr_q,  addr_d;
    logic [ID_W-1:0]      ptr_q,   ptr_d;
    logic [ID_W-1:0]      gid_q,   gid_d;
    logic                 vld_q;
    logic [ID_W-1:0]      id_q;

    logic [N_REQ-1:0]     w_elig;
    logic                 w_found;
    logic [ID_W-1:0]      w_win;
    int                   w_idx;

    // A requester granted last cycle sits out one cycle
    assign w_elig = req & ~gnt_q;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(ptr_q) + k) % N_REQ;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        gnt_d   = '0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        if (w_found) begin
            gnt_d[w_win] = 1'b1;
            rd_en_d      = 1'b1;
            addr_d       = {~wr_bank_q, req_addr[w_win*RD_ADDR_W +: RD_ADDR_W]};
            gid_d        = w_win;
            ptr_d        = (w_win == ID_W'(N_REQ-1)) ? '0 : w_win + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            gnt_q   <= gnt_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            // EBR port B has one cycle of read latency
            vld_q   <= rd_en_q;
            id_q    <= rd_en_q ? gid_q : id_q;
        end
    end

    assign wr_bank      = wr_bank_q;
    assign rd_bank      = ~wr_bank_q;
    assign gnt          = gnt_q;
    assign ebr_rd_en    = rd_en_q;
    assign ebr_addr_b   = addr_q;
    assign rd_valid     = vld_q;
    assign rd_id        = id_q;
    assign rd_data      = ebr_qb;
    assign frame_valid  = fvalid_q;
    assign frame_len_rd = len_rd_q;
    assign frame_seq    = seq_q;
    assign overrun_cnt  = ovr_q;
    assign swap_pending = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_dmx_frame_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmx_frame_bank_arbiter
// Purpose  : Directed self-checking bench for dmx_frame_bank_arbiter.
// Revision : 1.0
// ============================================================================
module tb_dmx_frame_bank_arbiter;

    localparam int N_REQ     = 4;
    localparam int RD_ADDR_W = 7;
    localparam int RD_DATA_W = 64;
    localparam int LEN_W     = 10;
    localparam int ID_W      = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       frame_done = 1'b0;
    logic [LEN_W-1:0]           frame_len = '0;
    logic                       wr_bank;
    logic [N_REQ-1:0]           req = '0;
    logic [N_REQ*RD_ADDR_W-1:0] req_addr = '0;
    logic [N_REQ-1:0]           lock = '0;
    logic [N_REQ-1:0]           gnt;
    logic                       ebr_rd_en;
    logic [RD_ADDR_W:0]         ebr_addr_b;
    logic [RD_DATA_W-1:0]       ebr_qb = '0;
    logic                       rd_valid;
    logic [ID_W-1:0]            rd_id;
    logic [RD_DATA_W-1:0]       rd_data;
    logic                       rd_bank;
    logic                       frame_valid;
    logic [LEN_W-1:0]           frame_len_rd;
    logic [7:0]                 frame_seq;
    logic [7:0]                 overrun_cnt;
    logic                       swap_pending;

    int n_tests = 0;
    int n_fail  = 0;

    dmx_frame_bank_arbiter #(
        .N_REQ(N_REQ), .RD_ADDR_W(RD_ADDR_W), .RD_DATA_W(RD_DATA_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done), .frame_len(frame_len),
        .wr_bank(wr_bank), .req(req), .req_addr(req_addr), .lock(lock), .gnt(gnt),
        .ebr_rd_en(ebr_rd_en), .ebr_addr_b(ebr_addr_b), .ebr_qb(ebr_qb),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .rd_bank(rd_bank),
        .frame_valid(frame_valid), .frame_len_rd(frame_len_rd), .frame_seq(frame_seq),
        .overrun_cnt(overrun_cnt), .swap_pending(swap_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ebr_word(input logic [7:0] a);
        return (a == 8'h85) ? 64'hA5 : {32'hDEAD_0000, 24'h0, a};
    endfunction

    // Registered-read EBR model
    always @(posedge clk)
        if (ebr_rd_en) ebr_qb <= ebr_word(ebr_addr_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".wr_bank"},      64'(wr_bank),      64'd0);
        check({tag, ".rd_bank"},      64'(rd_bank),      64'd1);
        check({tag, ".gnt"},          64'(gnt),          64'd0);
        check({tag, ".ebr_rd_en"},    64'(ebr_rd_en),    64'd0);
        check({tag, ".ebr_addr_b"},   64'(ebr_addr_b),   64'd0);
        check({tag, ".rd_valid"},     64'(rd_valid),     64'd0);
        check({tag, ".rd_id"},        64'(rd_id),        64'd0);
        check({tag, ".frame_valid"},  64'(frame_valid),  64'd0);
        check({tag, ".frame_len_rd"}, 64'(frame_len_rd), 64'd0);
        check({tag, ".frame_seq"},    64'(frame_seq),    64'd0);
        check({tag, ".overrun_cnt"},  64'(overrun_cnt),  64'd0);
        check({tag, ".swap_pending"}, 64'(swap_pending), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive at negedge, advance one active edge, settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic [LEN_W-1:0] len);
        @(negedge clk);
        frame_done = 1'b1;
        frame_len  = len;
        step();
        frame_done = 1'b0;
    endtask

    initial begin
        // Reset then idle
        do_reset();
        repeat (3) step();
        check_reset_state("idle");

        // Single read from requester 0, address 5 in bank 1
        @(negedge clk);
        req_addr[0 +: RD_ADDR_W] = 7'd5;
        req = 4'b0001;
        step();
        req = 4'b0000;
        check("single.gnt",  64'(gnt),        64'h1);
        check("single.en",   64'(ebr_rd_en),  64'h1);
        check("single.addr", 64'(ebr_addr_b), 64'h85);
        step();
        check("single.vld",  64'(rd_valid), 64'h1);
        check("single.id",   64'(rd_id),    64'h0);
        check("single.data", rd_data,       64'hA5);
        check("single.gnt0", 64'(gnt),      64'h0);

        // Full load: rotating grants, one per cycle
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++)
            req_addr[i*RD_ADDR_W +: RD_ADDR_W] = 7'(10 + i);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr.gnt%0d", k),  64'(gnt),        64'(1 << (k % 4)));
            check($sformatf("rr.addr%0d", k), 64'(ebr_addr_b), 64'(8'h80 | (10 + k % 4)));
            if (k > 0) begin
                check($sformatf("rr.vld%0d", k), 64'(rd_valid), 64'h1);
                check($sformatf("rr.id%0d", k),  64'(rd_id),    64'((k - 1) % 4));
                check($sformatf("rr.dat%0d", k), rd_data,
                      {32'hDEAD_0000, 24'h0, 8'(8'h80 | (10 + (k - 1) % 4))});
            end
        end
        req = 4'b0000;
        step();
        check("rr.tail_id", 64'(rd_id), 64'h3);
        check("rr.tail_gnt", 64'(gnt),  64'h0);

        // Unlocked frame swaps immediately
        pulse_frame(10'd512);
        check("swap.wr_bank", 64'(wr_bank),      64'd1);
        check("swap.rd_bank", 64'(rd_bank),      64'd0);
        check("swap.len",     64'(frame_len_rd), 64'd512);
        check("swap.seq",     64'(frame_seq),    64'd1);
        check("swap.valid",   64'(frame_valid),  64'd1);
        check("swap.pend",    64'(swap_pending), 64'd0);

        // Locked: two frames, one overrun, no swap
        @(negedge clk);
        lock = 4'b0100;
        pulse_frame(10'd100);
        check("lock1.pend", 64'(swap_pending), 64'd1);
        check("lock1.ovr",  64'(overrun_cnt),  64'd0);
        pulse_frame(10'd200);
        check("lock2.pend", 64'(swap_pending), 64'd1);
        check("lock2.ovr",  64'(overrun_cnt),  64'd1);
        check("lock2.wr",   64'(wr_bank),      64'd1);
        check("lock2.len",  64'(frame_len_rd), 64'd512);
        check("lock2.seq",  64'(frame_seq),    64'd1);
        @(negedge clk);
        lock = 4'b0000;
        step();
        check("rel.wr",   64'(wr_bank),      64'd0);
        check("rel.len",  64'(frame_len_rd), 64'd200);
        check("rel.seq",  64'(frame_seq),    64'd2);
        check("rel.pend", 64'(swap_pending), 64'd0);

        // Frame arriving on the release cycle: one swap, newest length, overrun
        @(negedge clk);
        lock = 4'b0001;
        pulse_frame(10'd300);
        check("same.pend0", 64'(swap_pending), 64'd1);
        @(negedge clk);
        lock = 4'b0000;
        frame_done = 1'b1;
        frame_len  = 10'd400;
        step();
        frame_done = 1'b0;
        check("same.wr",   64'(wr_bank),      64'd1);
        check("same.len",  64'(frame_len_rd), 64'd400);
        check("same.seq",  64'(frame_seq),    64'd3);
        check("same.ovr",  64'(overrun_cnt),  64'd2);
        check("same.pend", 64'(swap_pending), 64'd0);
        step();
        check("same.once", 64'(frame_seq),    64'd3);

        // Zero-length frame is ignored
        pulse_frame(10'd0);
        check("zero.seq",  64'(frame_seq),    64'd3);
        check("zero.len",  64'(frame_len_rd), 64'd400);
        check("zero.wr",   64'(wr_bank),      64'd1);
        check("zero.pend", 64'(swap_pending), 64'd0);

        // Grant on the swap cycle reads from the old bank (rd_bank=0)
        @(negedge clk);
        req_addr[0 +: RD_ADDR_W] = 7'd5;
        req        = 4'b0001;
        frame_done = 1'b1;
        frame_len  = 10'd7;
        step();
        req        = 4'b0000;
        frame_done = 1'b0;
        check("oldbank.addr", 64'(ebr_addr_b), 64'h05);
        check("oldbank.rdb",  64'(rd_bank),    64'd1);
        check("oldbank.len",  64'(frame_len_rd), 64'd7);
        step();
        check("oldbank.data", rd_data, {32'hDEAD_0000, 24'h0, 8'h05});

        // Async reset mid-burst with rd_valid high
        @(negedge clk);
        req = 4'b1111;
        step();
        step();
        check("rst.vld_pre", 64'(rd_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst");
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst.after_vld", 64'(rd_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
